// File: rtl/alu_result_buffer.sv
// rtl/alu_result_buffer.sv - two-entry result FIFO between the ALU result mux and writeback
// Flags are decoded from the registered head word; nothing combinational crosses from InData.
module alu_result_buffer #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             nReset,
    input  logic [WIDTH-1:0] InData,
    input  logic             InValid,
    output logic             InReady,
    output logic [WIDTH-1:0] OutData,
    output logic             OutZero,
    output logic             OutNeg,
    output logic             OutValid,
    input  logic             OutReady,
    input  logic             Flush,
    output logic [1:0]       Count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic             push;
    logic             pop;

    assign push = InValid && InReady;
    assign pop  = OutValid && OutReady;

    always_ff @(posedge CLK or negedge nReset) begin
        if (!nReset) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
        end else if (Flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        head  <= InData;
                        state <= ONE;
                    end
                end
                ONE: begin
                    // Simultaneous push and pop replaces the head in place.
                    if (push && pop) begin
                        head <= InData;
                    end else if (push) begin
                        tail  <= InData;
                        state <= FULL;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head  <= tail;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign Count    = state;
    assign InReady  = (state != FULL);
    assign OutValid = (state != EMPTY);
    // Stale storage stays hidden while the buffer is empty.
    assign OutData  = OutValid ? head : '0;
    assign OutZero  = OutValid && (head == '0);
    assign OutNeg   = OutData[WIDTH-1];

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb/tb_alu_result_buffer.sv - scoreboard bench for alu_result_buffer
// Reference is a plain queue of expected words; the monitor checks every cycle at the falling edge.
module tb_alu_result_buffer;

    localparam int WIDTH = 16;

    logic             CLK;
    logic             nReset;
    logic [WIDTH-1:0] InData;
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] OutData;
    logic             OutZero;
    logic             OutNeg;
    logic             OutValid;
    logic             OutReady;
    logic             Flush;
    logic [1:0]       Count;

    alu_result_buffer #(.WIDTH(WIDTH)) dut (
        .CLK      (CLK),
        .nReset   (nReset),
        .InData   (InData),
        .InValid  (InValid),
        .InReady  (InReady),
        .OutData  (OutData),
        .OutZero  (OutZero),
        .OutNeg   (OutNeg),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Flush    (Flush),
        .Count    (Count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [WIDTH-1:0] exp_q[$];
    bit               accept_pending;
    int               checks;
    int               errors;
    int               pops_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: outputs must match the queue; then apply the upcoming edge's pop/flush to the model.
    always @(negedge CLK) begin
        if (!nReset) begin
            exp_q.delete();
            accept_pending = 1'b0;
        end else begin
            int n;
            n = exp_q.size();
            chk("mon_count", 32'(Count), 32'(n));
            chk("mon_in_ready", 32'(InReady), 32'(n != 2));
            chk("mon_out_valid", 32'(OutValid), 32'(n != 0));
            if (n > 0) begin
                chk("mon_out_data", 32'(OutData), 32'(exp_q[0]));
                chk("mon_out_zero", 32'(OutZero), 32'(exp_q[0] == 0));
                chk("mon_out_neg", 32'(OutNeg), 32'(exp_q[0][WIDTH-1]));
            end else begin
                chk("mon_empty_data", 32'(OutData), 32'd0);
                chk("mon_empty_flags", 32'({OutZero, OutNeg}), 32'd0);
            end
            if (Flush) begin
                exp_q.delete();
                accept_pending = 1'b0;
            end else begin
                accept_pending = InValid && (n < 2);
                if (OutReady && n > 0) begin
                    void'(exp_q.pop_front());
                    pops_seen++;
                end
            end
        end
    end

    // Drive one cycle of inputs, let the edge happen, then record any accepted word.
    task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit r, input bit f);
        InValid  = v;
        InData   = d;
        OutReady = r;
        Flush    = f;
        @(posedge CLK);
        #1;
        if (accept_pending) exp_q.push_back(InData);
        accept_pending = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_count"}, 32'(Count), 32'd0);
        chk({tag, "_out_valid"}, 32'(OutValid), 32'd0);
        chk({tag, "_out_data"}, 32'(OutData), 32'd0);
        chk({tag, "_flags"}, 32'({OutZero, OutNeg}), 32'd0);
        chk({tag, "_in_ready"}, 32'(InReady), 32'd1);
    endtask

    logic [WIDTH-1:0] rdata;

    initial begin
        checks = 0;
        errors = 0;
        pops_seen = 0;
        accept_pending = 1'b0;
        nReset = 1'b0;
        InValid = 1'b0;
        InData = '0;
        OutReady = 1'b0;
        Flush = 1'b0;
        #3;
        check_reset_outputs("por");
        @(posedge CLK);
        #1;
        nReset = 1'b1;

        // Fill, then check the head and flags.
        drive(1, 16'h1234, 0, 0);
        drive(1, 16'h8000, 0, 0);
        chk("full_count", 32'(Count), 32'd2);
        chk("full_in_ready", 32'(InReady), 32'd0);
        chk("full_data", 32'(OutData), 32'h1234);
        chk("full_flags", 32'({OutNeg, OutZero}), 32'd0);

        drive(0, 16'h0, 1, 0);
        chk("promote_data", 32'(OutData), 32'h8000);
        chk("promote_neg", 32'(OutNeg), 32'd1);
        chk("promote_count", 32'(Count), 32'd1);
        chk("promote_in_ready", 32'(InReady), 32'd1);
        drive(0, 16'h0, 1, 0);
        chk("drained_count", 32'(Count), 32'd0);

        // Simultaneous push and pop while holding a zero word.
        drive(1, 16'h0000, 0, 0);
        chk("zero_flag", 32'(OutZero), 32'd1);
        drive(1, 16'h00FF, 1, 0);
        chk("pushpop_count", 32'(Count), 32'd1);
        chk("pushpop_data", 32'(OutData), 32'h00FF);
        chk("pushpop_zero", 32'(OutZero), 32'd0);
        drive(0, 16'h0, 1, 0);

        // Pushes into a full buffer must be ignored.
        drive(1, 16'hA5A5, 0, 0);
        drive(1, 16'h5A5A, 0, 0);
        repeat (3) drive(1, 16'hDEAD, 0, 0);
        chk("blocked_count", 32'(Count), 32'd2);
        chk("blocked_head", 32'(OutData), 32'hA5A5);
        drive(0, 16'h0, 1, 0);
        chk("blocked_second", 32'(OutData), 32'h5A5A);
        drive(0, 16'h0, 1, 0);
        chk("blocked_empty", 32'(Count), 32'd0);

        // Flush beats push and pop.
        drive(1, 16'h1111, 0, 0);
        drive(1, 16'h2222, 0, 0);
        drive(1, 16'h7777, 1, 1);
        chk("flush_count", 32'(Count), 32'd0);
        chk("flush_valid", 32'(OutValid), 32'd0);
        chk("flush_data", 32'(OutData), 32'd0);

        // Asynchronous reset between edges while full.
        drive(1, 16'h3333, 0, 0);
        drive(1, 16'h4444, 0, 0);
        InValid = 1'b0;
        #2;
        nReset = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge CLK);
        #1;
        check_reset_outputs("held_rst");
        nReset = 1'b1;
        drive(1, 16'h4321, 0, 0);
        chk("post_rst_data", 32'(OutData), 32'h4321);
        chk("post_rst_count", 32'(Count), 32'd1);
        drive(0, 16'h0, 1, 0);

        // Random traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0: rdata = 16'h0000;
                1: rdata = 16'h8000;
                default: rdata = 16'($urandom);
            endcase
            drive($urandom_range(0, 3) != 0, rdata, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 39) == 0);
        end
        repeat (3) drive(0, 16'h0, 1, 0);
        chk("final_empty", 32'(Count), 32'd0);
        if (pops_seen < 50) begin
            errors++;
            $display("FAIL pop_activity: got %0d pops, expected at least 50", pops_seen);
        end
        checks++;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 Parameter WIDTH, default 16: datapath width, matching the ALU result mux output.
REQ-002 CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 nReset  input  1  asynchronous, active-low reset.
REQ-004 InData  input  WIDTH  result word from the ALU result-select mux.
REQ-005 InValid  input  1  InData is valid this cycle.
REQ-006 InReady  output  1  the buffer accepts a word this cycle.
REQ-007 OutData  output  WIDTH  oldest buffered result.
REQ-008 OutZero  output  1  high when OutData equals zero.
REQ-009 OutNeg  output  1  equals OutData[WIDTH-1].
REQ-010 OutValid  output  1  OutData, OutZero and OutNeg are valid.
REQ-011 OutReady  input  1  the consumer (writeback) takes the word this cycle.
REQ-012 Flush  input  1  synchronous discard of all buffered words.
REQ-013 Count  output  2  number of buffered words, 0..2.

Function
REQ-014 The block SHALL be a 2-entry FIFO, with state EMPTY (Count=0), ONE (Count=1) or FULL (Count=2).
REQ-015 Push SHALL be InValid && InReady; pop SHALL be OutValid && OutReady; both are evaluated at the rising CLK edge.
REQ-016 InReady SHALL equal (Count != 2) and SHALL depend only on registered state, never on OutReady.
REQ-017 OutValid SHALL equal (Count != 0) and SHALL depend only on registered state.
REQ-018 OutData SHALL come from storage registers; there is no combinational path from InData to OutData.
REQ-019 Latency: a word pushed at edge N SHALL first appear on OutData after edge N, when it is the oldest entry.
REQ-020 OutZero and OutNeg SHALL be combinational decodes of OutData, and SHALL be 0 whenever OutValid is 0.
REQ-021 Transitions SHALL be: EMPTY to ONE on push; ONE to FULL on push without pop; ONE to EMPTY on pop without push; FULL to ONE on pop.
REQ-022 ONE with simultaneous push and pop SHALL stay ONE, and OutData SHALL become the new word on the next cycle.
REQ-023 FULL with InValid high SHALL not push; InData is ignored and no stored word changes.
REQ-024 In FULL, a pop SHALL promote the second entry to head, and that word SHALL appear on OutData on the next cycle.
REQ-025 Pop with Count=0 SHALL be impossible because OutValid=0; OutReady is a don't-care when EMPTY.
REQ-026 Ordering SHALL be strictly first-in-first-out, and no word SHALL be duplicated or lost except by Flush or reset.
REQ-027 Flush SHALL force EMPTY at the next edge and SHALL dominate any push or pop in the same cycle; the word on InData that cycle is discarded.
REQ-028 Storage register contents after Flush or pop are don't-care, but they SHALL never be visible while OutValid=0 (OutData driven to 0 when EMPTY).

Reset
REQ-029 When nReset is low, the block SHALL go to EMPTY immediately, regardless of CLK.
REQ-030 During reset, outputs SHALL be: Count=0, OutValid=0, OutData=0, OutZero=0, OutNeg=0, InReady=1.
REQ-031 InReady SHALL be 1 while nReset is low and after release.
REQ-032 Storage registers SHALL reset to 0.
REQ-033 Reset asserted mid-operation SHALL discard all buffered words, with no partial push or pop completing.
REQ-034 The first push SHALL be accepted at the first rising edge after nReset deasserts.

Verification
REQ-035 Push 0x1234 with OutReady=0, then push 0x8000 -> Count=2, InReady=0, OutData=0x1234, OutNeg=0, OutZero=0.
REQ-036 From that FULL state, raise OutReady for one cycle -> OutData=0x8000, OutNeg=1, Count=1, InReady=1.
REQ-037 In ONE holding 0x0000 (OutZero=1), push 0x00FF and pop in the same cycle -> Count=1, OutData=0x00FF, OutZero=0.
REQ-038 In FULL, hold InValid=1 with InData=0xDEAD for 3 cycles, then pop twice -> exactly the two original words emerge, and 0xDEAD never appears.
REQ-039 In FULL, assert Flush together with InValid=1 and OutReady=1 -> next cycle Count=0, OutValid=0, OutData=0.
REQ-040 Assert nReset=0 between clock edges while Count=2 -> outputs reach reset values before the next edge; the first push after release appears on OutData one cycle later.
